// File: rtl/par_data_rx_if.sv
// Bus between the per-wire TSPIN data receiver and whatever drives its line.
// The master side supplies the line and strobes; the slave side (the receiver) returns the payload.
interface par_data_rx_if #(
    parameter int ENC_DATA_BITS = 218
);
    logic                     enable;
    logic                     sample_en;
    logic                     serial_in;
    logic [ENC_DATA_BITS-1:0] pkt_data;
    logic                     pkt_valid;
    logic                     busy;
    logic [7:0]               pkt_count;

    modport master (
        output enable, sample_en, serial_in,
        input  pkt_data, pkt_valid, busy, pkt_count
    );

    modport slave (
        input  enable, sample_en, serial_in,
        output pkt_data, pkt_valid, busy, pkt_count
    );
endinterface

// File: rtl/par_data_rx.sv
// Per-wire TSPIN receiver: hunts for the all-ones syncword, then deserializes
// one ENC_DATA_BITS payload MSB first and presents it with a one-cycle valid pulse.
module par_data_rx #(
    parameter int SYNC_BITS     = 8,
    parameter int ENC_DATA_BITS = 218,
    parameter int CNT_W         = 8
) (
    input logic          clk,
    input logic          rst_l,
    par_data_rx_if.slave bus
);
    localparam int ONES_W = $clog2(SYNC_BITS + 1);

    typedef enum logic {
        HUNT,
        RECV
    } state_t;

    state_t                   state;
    logic [ONES_W-1:0]        ones_cnt;
    logic [CNT_W-1:0]         bit_cnt;
    logic [ENC_DATA_BITS-1:0] shreg;
    logic [ENC_DATA_BITS-1:0] shreg_next;
    logic [ENC_DATA_BITS-1:0] pkt_data;
    logic                     pkt_valid;
    logic                     busy;
    logic [7:0]               pkt_count;

    assign shreg_next = {shreg[ENC_DATA_BITS-2:0], bus.serial_in};

    assign bus.pkt_data  = pkt_data;
    assign bus.pkt_valid = pkt_valid;
    assign bus.busy      = busy;
    assign bus.pkt_count = pkt_count;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state     <= HUNT;
            ones_cnt  <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            pkt_data  <= '0;
            pkt_valid <= 1'b0;
            busy      <= 1'b0;
            pkt_count <= '0;
        end else begin
            pkt_valid <= 1'b0;
            if (!bus.enable) begin
                // Partial packet is dropped; pkt_data and pkt_count are kept.
                state    <= HUNT;
                ones_cnt <= '0;
                bit_cnt  <= '0;
                busy     <= 1'b0;
            end else if (bus.sample_en) begin
                case (state)
                    HUNT: begin
                        // Syncword is all ones, so a run counter is the whole matcher.
                        if (!bus.serial_in) begin
                            ones_cnt <= '0;
                        end else if (ones_cnt == ONES_W'(SYNC_BITS - 1)) begin
                            state    <= RECV;
                            busy     <= 1'b1;
                            ones_cnt <= '0;
                            bit_cnt  <= '0;
                        end else begin
                            ones_cnt <= ones_cnt + ONES_W'(1);
                        end
                    end
                    RECV: begin
                        shreg <= shreg_next;
                        if (bit_cnt == CNT_W'(ENC_DATA_BITS - 1)) begin
                            pkt_data  <= shreg_next;
                            pkt_valid <= 1'b1;
                            pkt_count <= pkt_count + 8'd1;
                            state     <= HUNT;
                            busy      <= 1'b0;
                            ones_cnt  <= '0;
                            bit_cnt   <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        state    <= HUNT;
                        busy     <= 1'b0;
                        ones_cnt <= '0;
                        bit_cnt  <= '0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_par_data_rx.sv
// Randomized and directed bench for par_data_rx, checked every cycle against
// a queue-based model of sync hunting and payload capture.
module tb_par_data_rx;
    localparam int N = 218;

    logic clk = 1'b0;
    logic rst_l = 1'b0;
    always #5 clk = ~clk;

    par_data_rx_if #(.ENC_DATA_BITS(N)) bus ();

    par_data_rx #(
        .SYNC_BITS    (8),
        .ENC_DATA_BITS(N),
        .CNT_W        (8)
    ) dut (
        .clk  (clk),
        .rst_l(rst_l),
        .bus  (bus)
    );

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Model: queue of samples since the last sync/reset/abort; in hunt mode the
    // queue holds only the current run of ones.
    bit           q[$];
    bit           hunting = 1'b1;
    logic [N-1:0] m_data  = '0;
    bit           m_valid = 1'b0;
    logic [7:0]   m_count = '0;
    int           valid_seen = 0;
    int           busy_seen  = 0;

    initial begin : monitor
        forever begin
            @(posedge clk);
            if (!rst_l) begin
                q.delete();
                hunting = 1'b1;
                m_data  = '0;
                m_valid = 1'b0;
                m_count = '0;
            end else begin
                m_valid = 1'b0;
                if (!bus.enable) begin
                    q.delete();
                    hunting = 1'b1;
                end else if (bus.sample_en) begin
                    if (hunting) begin
                        if (bus.serial_in) q.push_back(1'b1);
                        else q.delete();
                        if (q.size() == 8) begin
                            q.delete();
                            hunting = 1'b0;
                        end
                    end else begin
                        q.push_back(bus.serial_in);
                        if (q.size() == N) begin
                            for (int i = 0; i < N; i++) m_data[N-1-i] = q[i];
                            m_valid = 1'b1;
                            m_count = m_count + 8'd1;
                            hunting = 1'b1;
                            q.delete();
                        end
                    end
                end
            end
            #1;
            check("pkt_valid", 256'(bus.pkt_valid), 256'(m_valid));
            check("busy", 256'(bus.busy), 256'(!hunting));
            check("pkt_count", 256'(bus.pkt_count), 256'(m_count));
            check("pkt_data", 256'(bus.pkt_data), 256'(m_data));
            if (bus.pkt_valid) valid_seen++;
            if (bus.busy) busy_seen++;
        end
    end

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            bus.sample_en = 1'b0;
            bus.serial_in = 1'b0;
        end
    endtask

    task automatic send_bit(input logic b, input int gap);
        @(negedge clk);
        bus.sample_en = 1'b1;
        bus.serial_in = b;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            bus.sample_en = 1'b0;
            bus.serial_in = 1'($urandom);
        end
    endtask

    task automatic send_ones(input int n, input int gap);
        for (int k = 0; k < n; k++) send_bit(1'b1, gap);
    endtask

    task automatic send_payload(input logic [N-1:0] d, input int nbits, input int gap);
        for (int k = 0; k < nbits; k++) send_bit(d[N-1-k], gap);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_l         = 1'b0;
        bus.enable    = 1'b1;
        bus.sample_en = 1'b0;
        bus.serial_in = 1'b0;
        repeat (2) @(negedge clk);
        rst_l = 1'b1;
    endtask

    logic [N-1:0] pat;
    logic [N-1:0] pat_lit;
    logic [N-1:0] one_lit;
    int           v0;
    int           b0;

    initial begin : driver
        bus.enable    = 1'b0;
        bus.sample_en = 1'b0;
        bus.serial_in = 1'b0;
        for (int i = 0; i < N; i++) pat[i] = i[0];
        pat_lit = {2'b10, {54{4'hA}}};
        one_lit = '0;
        one_lit[0] = 1'b1;

        // Alternating payload, continuous strobe
        do_reset();
        check("reset_count", 256'(bus.pkt_count), 256'(0));
        check("reset_busy", 256'(bus.busy), 256'(0));
        v0 = valid_seen;
        b0 = busy_seen;
        send_ones(8, 0);
        send_payload(pat, N, 0);
        idle(3);
        check("alt_data", 256'(bus.pkt_data), 256'(pat_lit));
        check("alt_model", 256'(m_data), 256'(pat_lit));
        check("alt_count", 256'(bus.pkt_count), 256'(1));
        check("alt_pulses", 256'(valid_seen - v0), 256'(1));
        check("alt_busy_cycles", 256'(busy_seen - b0), 256'(218));

        // Short run of ones must not sync
        do_reset();
        v0 = valid_seen;
        send_ones(7, 0);
        send_bit(1'b0, 0);
        send_ones(8, 0);
        send_payload('0, N, 0);
        idle(3);
        check("short_run_data", 256'(bus.pkt_data), 256'(0));
        check("short_run_count", 256'(bus.pkt_count), 256'(1));
        check("short_run_pulses", 256'(valid_seen - v0), 256'(1));

        // Extra ones after sync become payload
        do_reset();
        v0 = valid_seen;
        send_ones(10, 0);
        send_payload('0, N - 2, 0);
        idle(3);
        check("long_run_data", 256'(bus.pkt_data), 256'({2'b11, 216'd0}));
        check("long_run_pulses", 256'(valid_seen - v0), 256'(1));

        // All-ones payload must not be mistaken for sync
        do_reset();
        v0 = valid_seen;
        send_ones(8, 0);
        send_payload('1, N, 0);
        send_ones(8, 0);
        send_payload(one_lit, N, 0);
        idle(3);
        check("b2b_data", 256'(bus.pkt_data), 256'(1));
        check("b2b_count", 256'(bus.pkt_count), 256'(2));
        check("b2b_pulses", 256'(valid_seen - v0), 256'(2));

        // Strobe every third cycle
        do_reset();
        send_ones(8, 2);
        send_payload(pat, N, 2);
        idle(2);
        check("strobe3_data", 256'(bus.pkt_data), 256'(pat_lit));
        check("strobe3_count", 256'(bus.pkt_count), 256'(1));

        // Enable drop mid-packet
        do_reset();
        send_ones(8, 0);
        send_payload(pat, N, 0);
        idle(2);
        v0 = valid_seen;
        send_ones(8, 0);
        send_payload('0, 100, 0);
        @(negedge clk);
        bus.enable    = 1'b0;
        bus.sample_en = 1'b1;
        bus.serial_in = 1'b1;
        @(negedge clk);
        check("en_drop_busy", 256'(bus.busy), 256'(0));
        bus.enable    = 1'b1;
        bus.sample_en = 1'b0;
        idle(N);
        check("en_drop_no_pulse", 256'(valid_seen - v0), 256'(0));
        check("en_drop_keeps_data", 256'(bus.pkt_data), 256'(pat_lit));
        check("en_drop_keeps_count", 256'(bus.pkt_count), 256'(1));

        // Reset mid-packet, then a clean packet
        send_ones(8, 0);
        send_payload('1, 150, 0);
        v0 = valid_seen;
        do_reset();
        check("rst_mid_busy", 256'(bus.busy), 256'(0));
        check("rst_mid_data", 256'(bus.pkt_data), 256'(0));
        send_ones(8, 1);
        send_payload(one_lit, N, 1);
        idle(2);
        check("rst_mid_pulses", 256'(valid_seen - v0), 256'(1));
        check("rst_mid_recovered", 256'(bus.pkt_data), 256'(1));
        check("rst_mid_count", 256'(bus.pkt_count), 256'(1));

        // Random traffic biased towards ones so syncs happen often
        for (int k = 0; k < 6000; k++) begin
            @(negedge clk);
            rst_l         = ($urandom_range(0, 2999) != 0);
            bus.enable    = ($urandom_range(0, 599) != 0);
            bus.sample_en = ($urandom_range(0, 2) != 0);
            bus.serial_in = ($urandom_range(0, 5) != 0);
        end
        idle(3);
        rst_l = 1'b1;
        idle(2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/par_data_rx.md
Name: par_data_rx

Overview:
- Per-wire serial receiver for the TSPIN data link; one instance per data line (NUM_DATA_LINES total).
- Hunts for the syncword, then deserializes one encoded data payload of ENC_DATA_BITS bits, MSB first.
- Presents the payload with a one-cycle valid pulse to the downstream Hamming decoder and packet assembler, which rebuild data_pkt_t.
- Sits directly downstream of the link pins and upstream of decode; performs no error correction itself.

Parameters:
- SYNC_BITS, 8, syncword length; syncword is all ones (SYNCWORD = 8'hff).
- ENC_DATA_BITS, 218, encoded payload bits per wire (PAR_DATA_BITS 209 + 9 parity).
- CNT_W, 8, width of the bit counter; must satisfy 2^CNT_W > ENC_DATA_BITS.

Ports:
- clk  input  1  system clock.
- rst_l  input  1  asynchronous, active-low reset.
- enable  input  1  receiver enable; low forces idle.
- sample_en  input  1  bit strobe; serial_in is sampled only on cycles where this is 1.
- serial_in  input  1  serial line, already synchronized to clk; idles low.
- pkt_data  output  ENC_DATA_BITS  last received encoded payload; first received bit lands at the MSB.
- pkt_valid  output  1  one-cycle pulse, high when pkt_data has just been updated.
- busy  output  1  high while in RECV.
- pkt_count  output  8  count of completed packets; wraps 255 -> 0.

Behaviour:
- Reset (rst_l low, asynchronous): state = HUNT, ones_cnt = 0, bit_cnt = 0, pkt_data = 0, pkt_valid = 0, busy = 0, pkt_count = 0.
- State HUNT:
  - On each sample_en cycle, serial_in = 1 increments ones_cnt; serial_in = 0 clears it.
  - When the sample that makes ones_cnt reach SYNC_BITS occurs, go to RECV with bit_cnt = 0 and ones_cnt = 0.
  - The next sampled bit, including a 1, is payload bit ENC_DATA_BITS-1 (MSB). Longer runs of ones are not absorbed as extra sync.
- State RECV:
  - On each sample_en cycle, shift serial_in into the internal shift register LSB end (shift left) and increment bit_cnt.
  - On the sample where bit_cnt == ENC_DATA_BITS-1:
    - Next edge loads pkt_data from the completed shift register and sets pkt_valid = 1.
    - pkt_count increments on the same edge.
    - State returns to HUNT with ones_cnt = 0.
  - Latency: pkt_valid is high in the cycle immediately after the edge that samples the last payload bit.
- pkt_valid is high for exactly one cycle and there is no backpressure; downstream must capture it on that cycle.
- pkt_data holds its value until the next completed packet and is never cleared by enable.
- Cycles with sample_en = 0 change no state or counters. pkt_valid still drops after its single cycle.
- Payload contents are never scanned for sync. Payload ones are not counted in HUNT, because ones_cnt is cleared on entry to HUNT.
- enable low (synchronous): next edge forces state = HUNT, ones_cnt = 0, bit_cnt = 0, and suppresses pkt_valid; a partial packet is discarded. pkt_data and pkt_count are unchanged. enable has priority over sample_en.
- Reset or enable drop mid-packet: no pkt_valid for that packet. A subsequent full sync + payload is received normally.
- busy = (state == RECV), registered.

Test Plan:
- Reset, then 8 ones followed by 218-bit payload 0x2AA..A pattern (alternating, MSB = 1), sample_en = 1 always -> pkt_valid high exactly one cycle after the 226th sampled bit; pkt_data equals pattern; pkt_count = 1; busy high for 218 cycles.
- 7 ones, one 0, then 8 ones + payload of all zeros -> first run does not sync; one packet, pkt_data = 0, pkt_count = 1.
- 10 ones, then 216 zeros -> payload MSB two bits = 2'b11, remainder zero; pkt_valid once.
- Payload of all ones, immediately followed by 8 ones + second payload 0x1 -> two pkt_valid pulses; second pkt_data = 1; pkt_count = 2; no false sync inside the first payload.
- sample_en = 1 every third cycle over a full packet -> same pkt_data as the continuous case; pkt_valid one cycle after the final strobed sample.
- enable dropped for one cycle at payload bit 100, and separately rst_l asserted at bit 150 -> no pkt_valid; busy low next cycle; pkt_data retains previous value after enable drop and is 0 after reset; the following clean packet is received correctly.
